// File: rtl/adder_result_acc.sv
// rtl/adder_result_acc.sv - accumulates fixed-length blocks of 9-bit adder results with saturation
// Optional build macro ADDER_ACC_FLUSH_EN adds a flush input that emits a partial block early.
module adder_result_acc #(
    parameter int BLOCK_LEN = 8,
    parameter int ACC_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_carry,
    input  logic [7:0]       in_sum,
    input  logic             clear,
`ifdef ADDER_ACC_FLUSH_EN
    input  logic             flush,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_total,
    output logic [7:0]       out_count,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    localparam logic [7:0]       BLOCK_LEN_C = 8'(BLOCK_LEN);
    localparam logic [ACC_W-1:0] ACC_MAX     = '1;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             accept;
    logic [ACC_W:0]   addend;
    logic [ACC_W:0]   add_full;

    assign in_ready = (state_q != EMIT);
    assign accept   = in_valid && in_ready;
    assign addend   = {{(ACC_W - 8){1'b0}}, in_carry, in_sum};
    // One spare bit above the accumulator exposes the carry used for saturation.
    assign add_full = {1'b0, acc_q} + addend;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc_d   = add_full[ACC_W] ? ACC_MAX : add_full[ACC_W-1:0];
                        ovf_d   = ovf_q | add_full[ACC_W];
                        count_d = count_q + 8'd1;
                        state_d = (count_d == BLOCK_LEN_C) ? EMIT : ACCUM;
                    end
`ifdef ADDER_ACC_FLUSH_EN
                    // The count already includes a result accepted on the same edge.
                    if (state_q == ACCUM && flush) begin
                        state_d = EMIT;
                    end
`endif
                end
                EMIT: begin
                    if (out_ready) begin
                        state_d = IDLE;
                        acc_d   = '0;
                        count_d = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid = (state_q == EMIT);
    assign out_total = acc_q;
    assign out_count = count_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_adder_result_acc.sv
// tb/tb_adder_result_acc.sv - self-checking bench for adder_result_acc (vector table, corner sequences, random vs model)
module tb_adder_result_acc;

    localparam int BLEN  = 8;
    localparam int ACCW  = 16;
    localparam int SBLEN = 4;
    localparam int SACCW = 10;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid, in_ready, in_carry, clear, out_valid, out_ready, overflow;
    logic [7:0]      in_sum, out_count;
    logic [ACCW-1:0] out_total;

    logic             s_in_valid, s_in_ready, s_in_carry, s_clear, s_out_valid, s_out_ready, s_overflow;
    logic [7:0]       s_in_sum, s_out_count;
    logic [SACCW-1:0] s_out_total;
`ifdef ADDER_ACC_FLUSH_EN
    logic flush;
    logic s_flush;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    adder_result_acc #(.BLOCK_LEN(BLEN), .ACC_W(ACCW)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_carry(in_carry), .in_sum(in_sum), .clear(clear),
`ifdef ADDER_ACC_FLUSH_EN
        .flush(flush),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_total(out_total),
        .out_count(out_count), .overflow(overflow)
    );

    adder_result_acc #(.BLOCK_LEN(SBLEN), .ACC_W(SACCW)) u_small (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_carry(s_in_carry), .in_sum(s_in_sum), .clear(s_clear),
`ifdef ADDER_ACC_FLUSH_EN
        .flush(s_flush),
`endif
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_total(s_out_total),
        .out_count(s_out_count), .overflow(s_overflow)
    );

    typedef struct {
        logic        carry;
        logic [7:0]  sum;
        logic [15:0] exp_total;
        logic [7:0]  exp_count;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic carry, input logic [7:0] sum, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_carry = carry;
            in_sum   = sum;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic feed_small(input logic carry, input logic [7:0] sum, input int n);
        for (int i = 0; i < n; i++) begin
            s_in_valid = 1'b1;
            s_in_carry = carry;
            s_in_sum   = sum;
            tick();
        end
        s_in_valid = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Reference state for the random phase: values accepted in the open block and a pending-emit flag.
    int unsigned mq[$];
    bit          mpend;

    function automatic int unsigned model_sum();
        int unsigned s = 0;
        foreach (mq[i]) s += mq[i];
        return s;
    endfunction

    initial begin
        vecs[0] = '{1'b0, 8'hFF, 16'h07F8, 8'd8, 1'b0};
        vecs[1] = '{1'b0, 8'h01, 16'h0008, 8'd8, 1'b0};
        vecs[2] = '{1'b0, 8'h02, 16'h0010, 8'd8, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 16'h0000, 8'd8, 1'b0};
        vecs[4] = '{1'b1, 8'hFF, 16'h0FF8, 8'd8, 1'b0};
        vecs[5] = '{1'b1, 8'h00, 16'h0800, 8'd8, 1'b0};

        rst_n = 1'b0;
        in_valid = 0; in_carry = 0; in_sum = 0; clear = 0; out_ready = 0;
        s_in_valid = 0; s_in_carry = 0; s_in_sum = 0; s_clear = 0; s_out_ready = 0;
`ifdef ADDER_ACC_FLUSH_EN
        flush = 0; s_flush = 0;
`endif
        #22;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_total", out_total, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_small_ready", s_in_ready, 1);
        tick();
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            feed(vecs[v].carry, vecs[v].sum, BLEN);
            chk($sformatf("vec%0d_out_valid", v), out_valid, 1);
            chk($sformatf("vec%0d_out_total", v), out_total, vecs[v].exp_total);
            chk($sformatf("vec%0d_out_count", v), out_count, vecs[v].exp_count);
            chk($sformatf("vec%0d_overflow", v), overflow, vecs[v].exp_ovf);
            chk($sformatf("vec%0d_in_ready", v), in_ready, 0);
            handshake();
            chk($sformatf("vec%0d_post_valid", v), out_valid, 0);
            chk($sformatf("vec%0d_post_ready", v), in_ready, 1);
        end

        // Saturation on the narrow instance.
        feed_small(1'b1, 8'hFF, 2);
        chk("sat_mid_total", s_out_total, 10'h3FE);
        chk("sat_mid_ovf", s_overflow, 0);
        feed_small(1'b1, 8'hFF, 1);
        chk("sat_third_ovf", s_overflow, 1);
        chk("sat_third_total", s_out_total, 10'h3FF);
        feed_small(1'b1, 8'hFF, 1);
        chk("sat_out_valid", s_out_valid, 1);
        chk("sat_out_total", s_out_total, 10'h3FF);
        chk("sat_out_count", s_out_count, 4);
        chk("sat_overflow", s_overflow, 1);
        s_out_ready = 1'b1;
        tick();
        s_out_ready = 1'b0;
        chk("sat_post_ovf", s_overflow, 0);
        chk("sat_post_valid", s_out_valid, 0);

        // Backpressure: total held, extra input ignored.
        feed(1'b0, 8'h01, BLEN);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_carry = 1'b0; in_sum = 8'h55;
            tick();
            chk("hold_out_valid", out_valid, 1);
            chk("hold_out_total", out_total, 16'h0008);
            chk("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        handshake();
        chk("hold_release_valid", out_valid, 0);
        chk("hold_release_ready", in_ready, 1);
        feed(1'b0, 8'h02, BLEN);
        chk("hold_next_total", out_total, 16'h0010);
        handshake();

        // Clear beats a simultaneous accept.
        feed(1'b0, 8'h10, 3);
        in_valid = 1'b1; in_sum = 8'h10; clear = 1'b1;
        tick();
        in_valid = 1'b0; clear = 1'b0;
        chk("clear_out_valid", out_valid, 0);
        chk("clear_count", out_count, 0);
        feed(1'b0, 8'h02, BLEN - 1);
        chk("clear_no_early", out_valid, 0);
        feed(1'b0, 8'h02, 1);
        chk("clear_next_valid", out_valid, 1);
        chk("clear_next_total", out_total, 16'h0010);
        handshake();

        // Clear also aborts a pending total.
        feed(1'b0, 8'h04, BLEN);
        clear = 1'b1; out_ready = 1'b1;
        tick();
        clear = 1'b0; out_ready = 1'b0;
        chk("clear_emit_valid", out_valid, 0);
        chk("clear_emit_ready", in_ready, 1);

        // Asynchronous reset mid-block.
        feed(1'b0, 8'h20, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_total", out_total, 0);
        chk("arst_out_count", out_count, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        #2 rst_n = 1'b1;
        tick();
        feed(1'b0, 8'h03, BLEN);
        chk("arst_next_total", out_total, 16'h0018);
        chk("arst_next_count", out_count, 8);
        handshake();

`ifdef ADDER_ACC_FLUSH_EN
        feed(1'b1, 8'h00, 3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_out_valid", out_valid, 1);
        chk("flush_out_total", out_total, 16'h0300);
        chk("flush_out_count", out_count, 3);
        handshake();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_idle_ignored", out_valid, 0);
`endif

        // Random traffic against the queue model; open with a clear so both start empty.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        mq.delete();
        mpend = 0;
        for (int c = 0; c < 3000; c++) begin
            int unsigned s;
            in_valid  = 1'($urandom_range(0, 1));
            in_carry  = 1'($urandom_range(0, 1));
            in_sum    = 8'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            clear     = ($urandom_range(0, 31) == 0);
            tick();
            if (clear) begin
                mq.delete();
                mpend = 0;
            end else if (mpend) begin
                if (out_ready) begin
                    mq.delete();
                    mpend = 0;
                end
            end else if (in_valid) begin
                mq.push_back({23'd0, in_carry, in_sum});
                if (mq.size() == BLEN) mpend = 1;
            end
            s = model_sum();
            chk("rnd_in_ready", in_ready, !mpend);
            chk("rnd_out_valid", out_valid, mpend);
            chk("rnd_overflow", overflow, s > 32'hFFFF);
            if (mpend) begin
                chk("rnd_out_total", out_total, (s > 32'hFFFF) ? 32'hFFFF : s);
                chk("rnd_out_count", out_count, mq.size());
            end
        end
        in_valid = 0; clear = 0; out_ready = 0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adder_result_acc.md
ADDER_RESULT_ACC -- requirements
Module: adder_result_acc

Interface
REQ-001 SHALL have parameter BLOCK_LEN, default 8, results per accumulation block (legal 1..255).
REQ-002 SHALL have parameter ACC_W, default 16, accumulator width (legal 10..32).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream adder result valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a result this cycle.
REQ-007 SHALL have port in_carry  input  1  adder carry-out.
REQ-008 SHALL have port in_sum  input  8  adder sum output.
REQ-009 SHALL have port clear  input  1  synchronous abort of current block.
REQ-010 SHALL have port out_valid  output  1  block total available.
REQ-011 SHALL have port out_ready  input  1  downstream accepts total.
REQ-012 SHALL have port out_total  output  ACC_W  accumulated block total.
REQ-013 SHALL have port out_count  output  8  number of results in emitted total.
REQ-014 SHALL have port overflow  output  1  sticky: current block saturated.

Function
REQ-015 SHALL implement states IDLE (count 0), ACCUM (0<count<BLOCK_LEN), EMIT (total held for output).
REQ-016 SHALL accept a result on a rising edge where in_valid=1 and in_ready=1; in_ready SHALL be 1 in IDLE/ACCUM, 0 in EMIT.
REQ-017 SHALL add the 9-bit value {in_carry,in_sum}, zero-extended to ACC_W, to the accumulator on each accept; count SHALL increment by 1.
REQ-018 SHALL transition IDLE->ACCUM on accept when BLOCK_LEN>1; on the accept making count==BLOCK_LEN (incl. BLOCK_LEN=1 from IDLE) SHALL enter EMIT.
REQ-019 SHALL assert out_valid the cycle after the edge accepting the final result (latency 1), with out_total=accumulator and out_count=BLOCK_LEN.
REQ-020 SHALL hold out_valid, out_total, out_count, overflow stable in EMIT until out_ready=1 at a rising edge.
REQ-021 On EMIT handshake SHALL clear accumulator, count and overflow, deassert out_valid, go IDLE; next result SHALL be accepted no earlier than the following cycle.
REQ-022 If an addition exceeds 2^ACC_W-1, SHALL saturate accumulator to all-ones and set overflow; further adds in that block SHALL keep saturation.
REQ-023 clear=1 at a rising edge SHALL, in any state, zero accumulator/count/overflow, deassert out_valid, enter IDLE; clear SHALL take priority over a simultaneous accept or EMIT handshake (result discarded).
REQ-024 in_valid while in_ready=0 SHALL be ignored (no accumulation); upstream holds data.
REQ-025 out_total/out_count values outside EMIT SHALL be don't-care for checking; out_valid is the sole qualifier.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, accumulator 0, count 0, out_valid 0, out_total 0, out_count 0, overflow 0; in_ready SHALL read 1 after reset.
REQ-027 Reset asserted mid-block or in EMIT SHALL discard the partial/pending total; no output handshake SHALL occur for it.

Configuration
REQ-028 With macro ADDER_ACC_FLUSH_EN defined SHALL add input port flush (1 bit); flush=1 in ACCUM SHALL enter EMIT next cycle with out_count=current count (including any result accepted that edge); flush in IDLE/EMIT SHALL be ignored; clear outranks flush.
REQ-029 Without ADDER_ACC_FLUSH_EN the flush port SHALL not exist and blocks SHALL emit only at count==BLOCK_LEN.

Verification
REQ-030 Defaults, 8 back-to-back results 0x0FF (carry 0,sum FF) with out_ready=1 -> one cycle after 8th accept out_valid=1, out_total=0x07F8, out_count=8, overflow=0.
REQ-031 ACC_W=10, BLOCK_LEN=4, four results 0x1FF -> out_total=0x3FF, overflow=1; after handshake overflow=0.
REQ-032 Defaults, 8 results value 1, out_ready=0 for 5 cycles -> out_valid held, total 0x0008 stable, in_ready=0, extra in_valid ignored; then out_ready=1 -> IDLE, in_ready=1.
REQ-033 3 results value 0x10 then clear=1 with in_valid=1 same edge -> no output; next 8 results value 2 give out_total=0x0010.
REQ-034 rst_n pulled low mid-block (count 5) asynchronously -> all outputs 0 without clock edge; fresh block of 8x value 3 gives 0x0018.
REQ-035 With ADDER_ACC_FLUSH_EN, 3 results 0x100 then flush=1 -> out_total=0x0300, out_count=3.
